muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative RV64M multiply/divide sequencer that takes over the multi-cycle M-extension work from the single-cycle execute path. When exu_top sees a muldiv instruction, it hands the operands and opcode to this block over a valid/ready request. The block runs a shift-add multiply or restoring divide FSM. It returns a 64-bit writeback value over a valid/ready response and asserts busy so the front end stalls issue.

Parameters:
XLEN, 64, datapath width; only 64 is supported (W ops use the low 32 bits).
EARLY_OUT, 1, when 1, divide-by-zero and signed-overflow cases skip CALC and complete in 1 cycle.

Ports:
core_clk  input  1  clock, all state updates on rising edge
core_rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (state IDLE)
req_op  input  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW, 13-15 reserved
req_src1  input  64  rs1 value (multiplicand/dividend)
req_src2  input  64  rs2 value (multiplier/divisor)
resp_valid  output  1  result available
resp_ready  input  1  consumer takes result
resp_data  output  64  result; W ops are sign-extended from bit 31
busy  output  1  high in CALC or DONE
flush  input  1  kill any in-flight op

Behaviour:
- Reset: state=IDLE, resp_valid=0, resp_data=0, busy=0, req_ready=1 (first cycle after reset deassert), iteration counter=0.
- States: IDLE, CALC, DONE.
  - IDLE: req_ready=1. Accept on req_valid&req_ready. Latch the op, operands, sign flags, and N (64, or 32 for ops 8-12).
    - Reserved op: go to DONE with result 0.
    - EARLY_OUT special case: go to DONE with the special result.
    - Otherwise go to CALC with counter=0.
  - CALC: one iteration per cycle, counter++. At counter==N-1, go to DONE with the final result registered.
  - DONE: resp_valid=1, resp_data stable. On resp_ready, return to IDLE. No new accept in DONE (req_ready=0).
- Latency: accept at cycle T.
  - Normal op: resp_valid first high at T+N+1 (T+65 for 64-bit, T+33 for W).
  - Early-out/reserved: resp_valid first high at T+1.
- Multiply: operands converted to magnitude per signedness:
  - MULH: both signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU/MUL: unsigned.
  - 128-bit shift-add product.
  - Result negated if the signs differ.
  - MUL returns the low 64 bits; MULH/MULHSU/MULHU return the high 64 bits.
  - MULW returns sext(low 32 of src1[31:0]*src2[31:0]).
- Divide: restoring algorithm on magnitudes, 1 quotient bit per cycle.
  - Quotient sign = sign(src1) XOR sign(src2).
  - Remainder sign = sign(src1).
  - W ops operate on bits [31:0], sign- or zero-extended per op before the divide; result is sign-extended from bit 31.
- Special cases (identical results whether EARLY_OUT is 0 or 1):
  - Divisor==0: DIV/DIVU/DIVW/DIVUW return all ones (64'hFFFF_FFFF_FFFF_FFFF); REM* return the dividend (W: sext of low 32).
  - Signed overflow (dividend=most negative, divisor=-1): DIV returns the dividend, REM returns 0. W variants use 32-bit most-negative 0x8000_0000 and the sext result.
- Flush:
  - Any state goes to IDLE next cycle; resp_valid=0 next cycle; counter cleared.
  - flush with req_valid in IDLE: request not accepted.
  - flush has priority over resp_ready and over acceptance.
- Simultaneous reset and flush: reset wins; identical end state.
- resp_data holds its last value after leaving DONE; consumers qualify it with resp_valid.

Test Plan:
- MUL src1=3, src2=5, resp_ready=1 -> resp_valid at T+65, resp_data=15; req_ready low T+1..T+65, high at T+66.
- MULH src1=-1 (all ones), src2=2 -> resp_data=64'hFFFF_FFFF_FFFF_FFFF; MULHU same operands -> resp_data=1.
- DIV src1=-7, src2=2 -> -3; REM -> -1. DIVW src1=64'h0000_0000_8000_0000, src2=-1 -> 64'hFFFF_FFFF_8000_0000 at T+1 (EARLY_OUT=1).
- DIVU src2=0 -> all ones at T+1; REMU src1=123, src2=0 -> 123.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_data stable, req_ready=0, new req_valid ignored; resp_ready=1 -> IDLE next cycle.
- Flush at CALC counter=20 -> resp_valid never asserts, req_ready=1 next cycle; immediate new MULW 6*7 -> 42 at T+33.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV64M multiply/divide sequencer.
// Shift-add multiply and restoring divide, one bit per cycle, with a
// valid/ready request and response handshake and a flush input.
module muldiv_seq #(
    parameter int unsigned XLEN      = 64,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            core_clk,
    input  logic            core_rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy,
    input  logic            flush
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state, w_state_next;

    logic [3:0]   r_op;
    logic         r_neg_a, r_neg_b, r_special;
    logic [63:0]  r_special_res;
    logic [5:0]   r_cnt, r_n_last;
    logic [127:0] r_acc, r_mcand;
    logic [63:0]  r_mplier, r_rem, r_quot, r_divisor;
    logic [63:0]  r_resp_data;

    // request decode and operand preparation
    logic         w_accept, w_is_w, w_s1, w_s2, w_is_div, w_is_rem, w_reserved;
    logic         w_div0, w_ovf, w_special, w_neg_a, w_neg_b;
    logic [63:0]  w_a64, w_b64, w_mag_a, w_mag_b, w_special_res, w_a_min;

    always_comb begin
        w_accept   = req_valid && (r_state == S_IDLE) && !flush;
        w_is_w     = req_op inside {[4'd8:4'd12]};
        w_s1       = req_op inside {4'd1, 4'd2, 4'd4, 4'd6, 4'd9, 4'd11};
        w_s2       = req_op inside {4'd1, 4'd4, 4'd6, 4'd9, 4'd11};
        w_is_div   = req_op inside {[4'd4:4'd7], [4'd9:4'd12]};
        w_is_rem   = req_op inside {4'd6, 4'd7, 4'd11, 4'd12};
        w_reserved = req_op >= 4'd13;
        if (w_is_w) begin
            w_a64 = w_s1 ? {{32{req_src1[31]}}, req_src1[31:0]} : {32'b0, req_src1[31:0]};
            w_b64 = w_s2 ? {{32{req_src2[31]}}, req_src2[31:0]} : {32'b0, req_src2[31:0]};
        end else begin
            w_a64 = req_src1;
            w_b64 = req_src2;
        end
        w_neg_a   = w_s1 && w_a64[63];
        w_neg_b   = w_s2 && w_b64[63];
        w_mag_a   = w_neg_a ? (64'd0 - w_a64) : w_a64;
        w_mag_b   = w_neg_b ? (64'd0 - w_b64) : w_b64;
        w_a_min   = w_is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        w_div0    = w_is_div && (w_b64 == '0);
        w_ovf     = w_is_div && w_s1 && w_s2 && (w_a64 == w_a_min) && (w_b64 == '1);
        w_special = w_div0 || w_ovf;
        if (w_div0) begin
            if (w_is_rem)
                w_special_res = w_is_w ? {{32{req_src1[31]}}, req_src1[31:0]} : req_src1;
            else
                w_special_res = '1;
        end else begin
            w_special_res = w_is_rem ? '0 : w_a64;
        end
    end

    // one iteration of each algorithm plus the final result formatting
    logic [127:0] w_acc_next, w_prod;
    logic [64:0]  w_trial;
    logic [63:0]  w_rem_next, w_quot_next, w_q64, w_qs, w_rs, w_result;

    always_comb begin
        w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_trial     = {r_rem, r_quot[63]} - {1'b0, r_divisor};
        w_rem_next  = w_trial[64] ? {r_rem[62:0], r_quot[63]} : w_trial[63:0];
        w_quot_next = {r_quot[62:0], ~w_trial[64]};
        w_prod      = (r_neg_a ^ r_neg_b) ? (128'd0 - w_acc_next) : w_acc_next;
        w_q64       = (r_op inside {[4'd8:4'd12]}) ? {32'b0, w_quot_next[31:0]} : w_quot_next;
        w_qs        = (r_neg_a ^ r_neg_b) ? (64'd0 - w_q64) : w_q64;
        w_rs        = r_neg_a ? (64'd0 - w_rem_next) : w_rem_next;
        w_result    = '0;
        case (r_op)
            4'd0:                w_result = w_prod[63:0];
            4'd1, 4'd2, 4'd3:    w_result = w_prod[127:64];
            4'd8:                w_result = {{32{w_prod[31]}}, w_prod[31:0]};
            4'd4, 4'd5:          w_result = w_qs;
            4'd6, 4'd7:          w_result = w_rs;
            4'd9, 4'd10:         w_result = {{32{w_qs[31]}}, w_qs[31:0]};
            4'd11, 4'd12:        w_result = {{32{w_rs[31]}}, w_rs[31:0]};
            default:             w_result = '0;
        endcase
        if (r_special)
            w_result = r_special_res;
    end

    // state register
    always_ff @(posedge core_clk) begin
        if (core_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // next-state logic; flush overrides every other transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_reserved || (EARLY_OUT && w_special))
                        w_state_next = S_DONE;
                    else
                        w_state_next = S_CALC;
                end
            end
            S_CALC: if (r_cnt == r_n_last) w_state_next = S_DONE;
            S_DONE: if (resp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush)
            w_state_next = S_IDLE;
    end

    // datapath: operand capture on accept, one iteration per CALC cycle
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_cnt       <= '0;
            r_resp_data <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op          <= req_op;
                        r_neg_a       <= w_neg_a;
                        r_neg_b       <= w_neg_b;
                        r_special     <= w_special;
                        r_special_res <= w_special_res;
                        r_n_last      <= w_is_w ? 6'd31 : 6'd63;
                        r_cnt         <= '0;
                        r_acc         <= '0;
                        r_mcand       <= {64'b0, w_mag_a};
                        r_mplier      <= w_mag_b;
                        r_rem         <= '0;
                        // W dividends are left-aligned so the MSB always enters at bit 63
                        r_quot        <= w_is_w ? {w_mag_a[31:0], 32'b0} : w_mag_a;
                        r_divisor     <= w_mag_b;
                        if (w_reserved)
                            r_resp_data <= '0;
                        else if (EARLY_OUT && w_special)
                            r_resp_data <= w_special_res;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_rem    <= w_rem_next;
                    r_quot   <= w_quot_next;
                    if (r_cnt == r_n_last) begin
                        r_cnt       <= '0;
                        r_resp_data <= w_result;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [63:0] req_src1 = '0;
    logic [63:0] req_src2 = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic        busy;
    logic        flush = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    muldiv_seq #(.XLEN(64), .EARLY_OUT(1'b1)) u_dut (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy),
        .flush      (flush)
    );

    always #5 core_clk = ~core_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the block back in IDLE.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int unsigned exp_lat, input string tag);
        int unsigned lat;
        int unsigned bad;
        lat = 0;
        bad = 0;
        check({tag, "_rdy_in"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_op     = op;
        req_src1   = a;
        req_src2   = b;
        resp_ready = 1'b1;
        do begin
            @(posedge core_clk);
            lat++;
            @(negedge core_clk);
            req_valid = 1'b0;
            if (req_ready !== 1'b0 || busy !== 1'b1) bad++;
        end while (!resp_valid && lat < 200);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, resp_data, exp);
        check({tag, "_busy"}, 64'(bad), 64'd0);
        @(negedge core_clk);
        check({tag, "_idle"}, {62'd0, req_ready, resp_valid}, 64'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned stable_bad;
        int unsigned valid_seen;

        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        core_rst = 1'b0;
        @(negedge core_clk);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);

        // multiplies
        run_op(4'd0, 64'd3, 64'd5, 64'd15, 65, "mul");
        run_op(4'd1, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "mulh");
        run_op(4'd3, '1, 64'd2, 64'd1, 65, "mulhu");
        run_op(4'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65, "mulhsu");
        run_op(4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu_max");

        // divides
        run_op(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div");
        run_op(4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, "rem");
        run_op(4'd5, 64'd1000, 64'd3, 64'd333, 65, "divu");
        run_op(4'd10, 64'hFFFF_FFFF_0000_0064, 64'h0000_0001_0000_0007, 64'd14, 33, "divuw");
        run_op(4'd11, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, "remw");

        // special cases and reserved opcode complete in one cycle
        run_op(4'd13, 64'd9, 64'd9, 64'd0, 1, "reserved");
        run_op(4'd9, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
        run_op(4'd11, 64'h0000_0000_8000_0000, '1, 64'd0, 1, "remw_ovf");
        run_op(4'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, "div_ovf");
        run_op(4'd5, 64'd55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "divu_zero");
        run_op(4'd7, 64'd123, 64'd0, 64'd123, 1, "remu_zero");
        run_op(4'd12, 64'h1234_5678_8765_4321, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8765_4321, 1, "remuw_zero");

        // backpressure: hold the result in DONE, new requests ignored
        req_valid  = 1'b1;
        req_op     = 4'd5;
        req_src1   = 64'd77;
        req_src2   = 64'd0;
        resp_ready = 1'b0;
        @(negedge core_clk);
        req_op   = 4'd0;
        req_src1 = 64'd2;
        req_src2 = 64'd2;
        stable_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid !== 1'b1 || resp_data !== 64'hFFFF_FFFF_FFFF_FFFF || req_ready !== 1'b0)
                stable_bad++;
            @(negedge core_clk);
        end
        check("bp_stable", 64'(stable_bad), 64'd0);
        check("bp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge core_clk);
        check("bp_release", {62'd0, req_ready, resp_valid}, 64'd2);
        check("bp_not_taken", 64'(busy), 64'd0);

        // flush with a request in IDLE: nothing accepted
        req_valid = 1'b1;
        req_op    = 4'd0;
        flush     = 1'b1;
        @(negedge core_clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'd0);

        // flush mid-calculation at counter 20
        req_valid = 1'b1;
        req_op    = 4'd0;
        req_src1  = 64'd11;
        req_src2  = 64'd13;
        @(posedge core_clk);
        @(negedge core_clk);
        req_valid = 1'b0;
        repeat (20) @(posedge core_clk);
        @(negedge core_clk);
        check("flush_pre_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge core_clk);
        flush = 1'b0;
        check("flush_state", {61'd0, req_ready, resp_valid, busy}, 64'd4);
        run_op(4'd8, 64'hABCD_0000_0000_0006, 64'hFFFF_0000_0000_0007, 64'd42, 33, "mulw_after_flush");

        // the killed multiply must never surface
        valid_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge core_clk);
            if (resp_valid !== 1'b0) valid_seen++;
        end
        check("flush_no_resp", 64'(valid_seen), 64'd0);

        // reset mid-operation returns to the reset state
        req_valid = 1'b1;
        req_op    = 4'd5;
        req_src1  = 64'd100;
        req_src2  = 64'd9;
        @(negedge core_clk);
        req_valid = 1'b0;
        core_rst  = 1'b1;
        flush     = 1'b1;
        @(negedge core_clk);
        core_rst = 1'b0;
        flush    = 1'b0;
        check("rst_flush_state", {61'd0, req_ready, resp_valid, busy}, 64'd4);
        check("rst_flush_data", resp_data, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
